// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the ROB write-back port between result producers
//
// Each producer feeds a small age-ordered skid queue. One queue head per cycle is
// granted onto a registered write-back bus. Queued entries follow branch resolution:
// a mispredict discards dependent entries, a correct resolve clears the dependency bit.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rdy                 global enable; low freezes every register
//   req_valid/tag/data/btag   per-producer result, slice i belongs to producer i
//   req_ready           per-producer queue can accept (registered state and rdy only)
//   bFreeEn/bFreeNum/misTaken branch resolve broadcast
//   enWrtO/WrtTagO/WrtDataO   registered write-back bus
//   grant_id            producer that supplied the current enWrtO pulse
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int BTAG_W  = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = 4'b1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*BTAG_W-1:0] req_btag,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      bFreeEn,
    input  logic [1:0]                bFreeNum,
    input  logic                      misTaken,
    output logic                      enWrtO,
    output logic [TAG_W-1:0]          WrtTagO,
    output logic [DATA_W-1:0]         WrtDataO,
    output logic [1:0]                grant_id
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  q_tag  [NUM_REQ][DEPTH];
    logic [DATA_W-1:0] q_data [NUM_REQ][DEPTH];
    logic [BTAG_W-1:0] q_btag [NUM_REQ][DEPTH];
    logic [CW-1:0]     q_cnt  [NUM_REQ];
    logic [1:0]        ptr;

    logic [TAG_W-1:0]  n_tag  [NUM_REQ][DEPTH];
    logic [DATA_W-1:0] n_data [NUM_REQ][DEPTH];
    logic [BTAG_W-1:0] n_btag [NUM_REQ][DEPTH];
    logic [CW-1:0]     n_cnt  [NUM_REQ];

    logic               kill;
    logic               clr;
    logic [BTAG_W-1:0]  bmask;
    logic [NUM_REQ-1:0] elig;
    logic               gnt;
    logic [1:0]         win;
    logic [TAG_W-1:0]   win_tag;
    logic [DATA_W-1:0]  win_data;

    assign kill  = bFreeEn & misTaken;
    assign clr   = bFreeEn & ~misTaken;
    assign bmask = BTAG_W'(1) << bFreeNum;

    // Pre-pop fullness only, so a producer never sees ready combinationally follow valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = rst & rdy & (q_cnt[i] != CW'(DEPTH));
    end

    // Round-robin: the eligible queue closest to ptr (in wrap-around distance) wins.
    always_comb begin
        int d;
        int best;
        d        = 0;
        best     = NUM_REQ;
        elig     = '0;
        win      = '0;
        win_tag  = '0;
        win_data = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            elig[c] = (q_cnt[c] != '0) && !(kill && (|(q_btag[c][0] & bmask)));
            d = c - int'(ptr);
            if (d < 0)
                d = d + NUM_REQ;
            if (elig[c] && (d < best)) begin
                best     = d;
                win      = 2'(c);
                win_tag  = q_tag[c][0];
                win_data = q_data[c][0];
            end
        end
        gnt = rdy && (best < NUM_REQ);
    end

    // Next queue contents: survivors (not discarded, not popped) packed toward the head
    // in age order, then the incoming entry if it survives the same mask update.
    always_comb begin
        int                run;
        logic              keep;
        logic              pop_i;
        logic              push_keep;
        logic [BTAG_W-1:0] bt;
        logic [BTAG_W-1:0] in_bt;
        run       = 0;
        keep      = 1'b0;
        pop_i     = 1'b0;
        push_keep = 1'b0;
        bt        = '0;
        in_bt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_i     = gnt && (win == 2'(i));
            in_bt     = req_btag[i*BTAG_W +: BTAG_W];
            push_keep = rdy & req_valid[i] & req_ready[i] & ~(kill & (|(in_bt & bmask)));
            if (clr)
                in_bt = in_bt & ~bmask;
            for (int k = 0; k < DEPTH; k++) begin
                n_tag[i][k]  = q_tag[i][k];
                n_data[i][k] = q_data[i][k];
                n_btag[i][k] = q_btag[i][k];
                run = 0;
                for (int j = 0; j < DEPTH; j++) begin
                    bt   = q_btag[i][j];
                    keep = (CW'(j) < q_cnt[i]) && !(kill && (|(bt & bmask))) && !(pop_i && (j == 0));
                    if (keep) begin
                        if (run == k) begin
                            n_tag[i][k]  = q_tag[i][j];
                            n_data[i][k] = q_data[i][j];
                            n_btag[i][k] = clr ? (bt & ~bmask) : bt;
                        end
                        run = run + 1;
                    end
                end
                if (push_keep && (run == k)) begin
                    n_tag[i][k]  = req_tag[i*TAG_W +: TAG_W];
                    n_data[i][k] = req_data[i*DATA_W +: DATA_W];
                    n_btag[i][k] = in_bt;
                end
            end
            n_cnt[i] = CW'(run) + CW'(push_keep);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                q_cnt[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    q_tag[i][j]  <= '0;
                    q_data[i][j] <= '0;
                    q_btag[i][j] <= '0;
                end
            end
            ptr      <= '0;
            enWrtO   <= 1'b0;
            WrtTagO  <= TAG_FREE;
            WrtDataO <= '0;
            grant_id <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                q_cnt[i] <= n_cnt[i];
                for (int j = 0; j < DEPTH; j++) begin
                    q_tag[i][j]  <= n_tag[i][j];
                    q_data[i][j] <= n_data[i][j];
                    q_btag[i][j] <= n_btag[i][j];
                end
            end
            if (gnt) begin
                ptr      <= (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
                grant_id <= win;
            end
            enWrtO   <= gnt;
            WrtTagO  <= gnt ? win_tag : TAG_FREE;
            WrtDataO <= gnt ? win_data : '0;
        end
    end
endmodule
